crc_access_arb: RTL

CRC_ACCESS_ARB -- requirements
Module: crc_access_arb

---
 rtl/crc_access_arb_pkg.sv | 15 +
 rtl/crc_access_arb_lfsr.sv | 34 +++
 rtl/crc_access_arb.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/crc_access_arb_pkg.sv
// Shared definitions for the CRC access arbiter: FSM state encoding and
// default geometry of the data word, CRC and serial message.
package crc_access_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned CRC_W_DEF  = 3;
  localparam int unsigned MSG_LEN    = DATA_W_DEF + CRC_W_DEF;

endpackage

// File: rtl/crc_access_arb_lfsr.sv
// Serial polynomial divider: consumes one message bit per enabled edge, MSB
// first, and keeps the running remainder. The generator's leading 1 is implicit.
module crc_lfsr #(
  parameter int unsigned CRC_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  input  logic [CRC_W-1:0] poly,
  output logic [CRC_W-1:0] rem
);

  logic [CRC_W-1:0] rem_q;
  logic [CRC_W-1:0] rem_d;

  always_comb begin
    rem_d = rem_q;
    if (clr) begin
      rem_d = '0;
    end else if (en) begin
      rem_d = {rem_q[CRC_W-2:0], bit_in} ^ (rem_q[CRC_W-1] ? poly : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rem_q <= '0;
    else     rem_q <= rem_d;
  end

  assign rem = rem_q;

endmodule

// File: rtl/crc_access_arb.sv
// Two-requester round-robin arbiter in front of a serial CRC divider:
// write side generates a CRC, read side checks a stored one.
module crc_access_arb
  import crc_access_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CRC_W  = CRC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CRC_W:0]    poly,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [CRC_W-1:0]  rd_crc,
  output logic              wr_gnt,
  output logic              rd_gnt,
  output logic              busy,
  output logic              done,
  output logic              done_src,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_err
);

  localparam int unsigned MSG_W = DATA_W + CRC_W;
  localparam int unsigned CNT_W = $clog2(MSG_W);

  state_e            state_q, state_d;
  logic [MSG_W-1:0]  msg_q, msg_d;
  logic [CRC_W-1:0]  poly_q, poly_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              src_q, src_d;
  logic              last_q, last_d;
  logic              wr_gnt_q, wr_gnt_d;
  logic              rd_gnt_q, rd_gnt_d;
  logic              out_src_q, out_src_d;
  logic [CRC_W-1:0]  out_rem_q, out_rem_d;
  logic              out_err_q, out_err_d;
  logic              pick_rd;
  logic              lfsr_clr;
  logic              lfsr_en;
  logic [CRC_W-1:0]  rem;
  logic              unused_poly_msb;

  // Generator MSB is always taken as 1, so the input bit is deliberately ignored.
  assign unused_poly_msb = poly[CRC_W];

  // last_q = 1 means read was served last, so write wins a tie.
  assign pick_rd = rd_req & (~wr_req | ~last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    msg_d     = msg_q;
    poly_d    = poly_q;
    cnt_d     = cnt_q;
    src_d     = src_q;
    last_d    = last_q;
    out_src_d = out_src_q;
    out_rem_d = out_rem_q;
    out_err_d = out_err_q;
    wr_gnt_d  = 1'b0;
    rd_gnt_d  = 1'b0;
    lfsr_clr  = 1'b0;
    lfsr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_req | rd_req) begin
          src_d    = pick_rd;
          last_d   = pick_rd;
          poly_d   = poly[CRC_W-1:0];
          msg_d    = pick_rd ? {rd_data, rd_crc} : {wr_data, {CRC_W{1'b0}}};
          cnt_d    = '0;
          lfsr_clr = 1'b1;
          wr_gnt_d = ~pick_rd;
          rd_gnt_d = pick_rd;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        lfsr_en = 1'b1;
        msg_d   = msg_q << 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MSG_W - 1)) begin
          out_src_d = src_q;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        out_rem_d = rem;
        out_err_d = src_q & (|rem);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_q     <= '0;
      poly_q    <= '0;
      cnt_q     <= '0;
      src_q     <= 1'b0;
      last_q    <= 1'b1;
      wr_gnt_q  <= 1'b0;
      rd_gnt_q  <= 1'b0;
      out_src_q <= 1'b0;
      out_rem_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      msg_q     <= msg_d;
      poly_q    <= poly_d;
      cnt_q     <= cnt_d;
      src_q     <= src_d;
      last_q    <= last_d;
      wr_gnt_q  <= wr_gnt_d;
      rd_gnt_q  <= rd_gnt_d;
      out_src_q <= out_src_d;
      out_rem_q <= out_rem_d;
      out_err_q <= out_err_d;
    end
  end

  crc_lfsr #(.CRC_W(CRC_W)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .clr    (lfsr_clr),
    .en     (lfsr_en),
    .bit_in (msg_q[MSG_W-1]),
    .poly   (poly_q),
    .rem    (rem)
  );

  // The divider already holds the final remainder during DONE; the result is
  // presented from it there and latched into the hold registers on leaving DONE.
  assign done     = (state_q == ST_DONE);
  assign busy     = (state_q != ST_IDLE);
  assign wr_gnt   = wr_gnt_q;
  assign rd_gnt   = rd_gnt_q;
  assign done_src = out_src_q;
  assign crc_out  = done ? rem : out_rem_q;
  assign crc_err  = done ? (src_q & (|rem)) : out_err_q;

endmodule
